instr_prefetch_unit: RTL
========================

// Module: instr_prefetch_unit
//
// PURPOSE
//   Instruction fetch front end that sits directly upstream of the RISC-V datapath.
//   Generates sequential word addresses to instruction memory over a req/rsp handshake.
//   Buffers returned instructions in a small in-order FIFO.
//   Presents {pc, instruction} to the datapath over a valid/ready handshake.
//   A datapath redirect (branch/jump) flushes the buffer and discards stale responses.
//
// PARAMETERS
//   XLEN      32  address/data width
//   DEPTH     4   prefetch FIFO entries; also max outstanding requests (power of 2, >=2)
//   RESET_PC  0   fetch address after reset (word aligned)
//
// PORTS
//   clk            in   1     clock, all state updates on rising edge
//   reset          in   1     synchronous, active-low reset
//   mem_req_valid  out  1     fetch request valid
//   mem_req_addr   out  XLEN  fetch address, bits [1:0] always 0
//   mem_req_ready  in   1     memory accepts request this cycle
//   mem_rsp_valid  in   1     response data valid (in order, latency >=1 cycle)
//   mem_rsp_data   in   XLEN  instruction word
//   redirect_valid in   1     datapath requests new fetch stream
//   redirect_pc    in   XLEN  new fetch address, bits [1:0] ignored (forced to 0)
//   inst_valid     out  1     head of FIFO valid
//   inst_pc        out  XLEN  pc of head instruction
//   inst_data      out  XLEN  head instruction word
//   inst_ready     in   1     datapath consumes head this cycle
//
// BEHAVIOUR
//   - Reset (reset==0 at posedge):
//     - fetch_pc = RESET_PC; FIFO emptied; inflight = 0; discard = 0.
//     - mem_req_valid = 0 and inst_valid = 0 while reset is low.
//   - Issue rule: mem_req_valid = !redirect_valid && (fifo_count + inflight < DEPTH).
//   - Request accept (mem_req_valid && mem_req_ready):
//     - fetch_pc += 4, wrapping modulo 2^XLEN (0xFFFFFFFC -> 0x0).
//     - inflight += 1.
//     - Each request carries its pc in a tag queue for pairing with its response.
//   - Response (mem_rsp_valid):
//     - If inflight == 0: ignored (covers stale traffic after reset).
//     - Else inflight -= 1.
//     - If discard > 0: discard -= 1 and the word is dropped.
//     - Otherwise push {tag pc, data} into the FIFO.
//     - The FIFO is never full on push, guaranteed by the credit rule.
//   - Output: inst_valid = (fifo_count != 0) && !redirect_valid; pop on inst_valid && inst_ready.
//     - Zero-bubble pop+push in the same cycle is allowed.
//     - Latency: a response pushed at edge N is visible on inst_* after edge N (registered FIFO).
//   - Redirect (redirect_valid at posedge), priority over every other event in that cycle:
//     - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}; FIFO flushed (count = 0).
//     - No request issues and no pop occurs in that cycle.
//     - discard = inflight - (this-cycle response counted ? 1 : 0); all in-flight words are dropped.
//     - First post-redirect request issues on the next cycle when credit allows.
//     - Back-to-back redirects: the last one wins; discard recomputed from the current inflight.
//   - Counters are clog2(DEPTH)+1 bits; inflight <= DEPTH and discard <= inflight always hold.
//
// TESTING
//   1. Reset release, ready=1, 1-cycle memory:
//      - mem_req_addr = 0x0, 0x4, 0x8, ... on consecutive cycles.
//      - inst_pc follows the same sequence, one instruction per cycle once full.
//   2. inst_ready held 0:
//      - Exactly DEPTH=4 requests issue (0x0..0xC), then mem_req_valid stays 0.
//      - After one pop, exactly one new request issues (0x10).
//   3. 3-cycle memory latency, 3 requests in flight, redirect_pc=0x103:
//      - The 3 stale responses are dropped and inst_valid stays 0.
//      - Next request addr is 0x100; first inst_pc is 0x100.
//   4. Redirect in the same cycle as a response and an inst_ready handshake:
//      - No pop is counted and that response is dropped.
//      - FIFO is empty on the next cycle; inst_valid = 0 during the redirect cycle.
//   5. Redirect to 0xFFFFFFF8:
//      - Request addresses are 0xFFFFFFF8, 0xFFFFFFFC, then 0x0.
//   6. reset low for one cycle with 2 requests in flight:
//      - All outputs are 0 during reset; late responses with inflight == 0 are ignored.
//      - Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_prefetch_unit.sv
`timescale 1ns/1ps
// Instruction prefetch front end: sequential word fetch over req/rsp,
// in-order prefetch FIFO, valid/ready delivery of {pc, inst}, and
// redirect flush that discards every response still in flight.
module instr_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_data,
  input  logic            inst_ready
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_ent_t;

  logic [XLEN-1:0]              fetch_pc;
  logic [CW-1:0]                inflight, discard, count;
  logic [AW-1:0]                wptr, rptr, tag_wptr, tag_rptr;
  fetch_ent_t [DEPTH-1:0]       fifo_q;
  logic [DEPTH-1:0][XLEN-1:0]   tag_q;

  logic [CW:0]     occ;
  logic            credit, acc, rsp_cnt, push, pop;
  logic [XLEN-1:0] redir_aligned;
  fetch_ent_t      head;

  // Credit: buffered words plus outstanding requests never exceed DEPTH,
  // so every counted response has a free FIFO slot.
  assign occ           = {1'b0, count} + {1'b0, inflight};
  assign credit        = occ < DEPTH_C;
  assign redir_aligned = redirect_pc & ~XLEN'(3);

  assign mem_req_valid = reset && !redirect_valid && credit;
  assign acc           = mem_req_valid && mem_req_ready;
  // Responses with nothing outstanding are stale traffic from before reset.
  assign rsp_cnt       = mem_rsp_valid && (inflight != '0);
  assign push          = rsp_cnt && (discard == '0) && !redirect_valid;

  assign head          = fifo_q[rptr];
  assign inst_valid    = reset && (count != '0) && !redirect_valid;
  assign pop           = inst_valid && inst_ready;

  assign mem_req_addr  = reset ? fetch_pc  : '0;
  assign inst_pc       = reset ? head.pc   : '0;
  assign inst_data     = reset ? head.data : '0;

  // Control state: fetch pc, credit/discard counters, FIFO and tag pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      tag_wptr <= '0;
      tag_rptr <= '0;
    end else begin
      inflight <= inflight + CW'(acc) - CW'(rsp_cnt);
      if (acc)     tag_wptr <= tag_wptr + AW'(1);
      if (rsp_cnt) tag_rptr <= tag_rptr + AW'(1);
      if (redirect_valid) begin
        // Everything still in flight belongs to the old stream.
        fetch_pc <= redir_aligned;
        discard  <= inflight - CW'(rsp_cnt);
        count    <= '0;
        wptr     <= '0;
        rptr     <= '0;
      end else begin
        if (acc)                        fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_cnt && discard != '0)   discard  <= discard - CW'(1);
        if (push)                       wptr     <= wptr + AW'(1);
        if (pop)                        rptr     <= rptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage: tag queue keeps the pc of each outstanding request so the
  // in-order response can be paired with it on the way into the FIFO.
  always_ff @(posedge clk) begin
    if (acc)  tag_q[tag_wptr] <= fetch_pc;
    if (push) fifo_q[wptr]    <= '{pc: tag_q[tag_rptr], data: mem_rsp_data};
  end

endmodule
